// File: rtl/decode_stage.sv
// Registered decode stage for the 9-bit ISA with valid/ready handshake, flush and IMX prefix.
// Optional illegal-opcode trap (out_illegal, err_sticky) is built when DECODE_ILLEGAL_TRAP_EN is defined.
//
// state | meaning
// IDLE  | no prefix pending; jump immediates use {4'b0, i[3:0]}
// PFX   | IMX accepted; next jump immediate uses {pfx, i[3:0]}
module decode_stage #(
    parameter int RW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [8:0]    instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] reg0,
    output logic [RW-1:0] reg1,
    output logic [DW-1:0] imm,
    output logic          use_imm,
    output logic          imm_as_input_b,
    output logic          use_other_reg_bus,
    output logic          out_illegal,
    output logic          err_sticky
);

    typedef enum logic {
        IDLE = 1'b0,
        PFX  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pfx_q, pfx_d;
    logic          accept;

    logic [RW-1:0] d_reg0, d_reg1;
    logic [DW-1:0] d_imm;
    logic          d_use_imm, d_imm_b, d_other;
    logic          is_imx, is_illegal;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        d_reg0     = '0;
        d_reg1     = '0;
        d_imm      = '0;
        d_use_imm  = 1'b0;
        d_imm_b    = 1'b0;
        d_other    = 1'b0;
        is_imx     = 1'b0;
        is_illegal = 1'b0;
        casez (instr)
            9'b00???????: begin
                d_reg0 = RW'(instr[5:3]);
                d_reg1 = RW'(instr[2:0]);
            end
            9'b01???????: begin
                d_reg0 = RW'(instr[3:2]);
                d_reg1 = RW'(instr[1:0]);
            end
            9'b100??????: begin
                d_use_imm = 1'b1;
                d_imm     = (state_q == PFX) ? DW'({pfx_q, instr[3:0]}) : DW'(instr[3:0]);
            end
            9'b101010???: begin
                d_reg1  = RW'(instr[2:0]);
                d_imm_b = 1'b1;
            end
            9'b101110???: begin
                d_reg1  = RW'(instr[2:0]);
                d_other = 1'b1;
            end
            9'b101000???, 9'b101001???, 9'b101011???,
            9'b10110????, 9'b101111???: begin
                d_reg0 = RW'(instr[2:0]);
            end
            9'b11000????: begin
                d_use_imm = 1'b1;
                d_imm     = DW'({5'b01000, instr[2:0]});
            end
            9'b11001????: is_imx = 1'b1;
            default:      is_illegal = 1'b1;
        endcase
    end

    // Flush wins over accept; any accepted non-IMX instruction consumes the prefix.
    always_comb begin
        state_d = state_q;
        pfx_d   = pfx_q;
        if (flush) begin
            state_d = IDLE;
            pfx_d   = 4'h0;
        end else if (accept) begin
            if (is_imx) begin
                state_d = PFX;
                pfx_d   = instr[3:0];
            end else begin
                state_d = IDLE;
                pfx_d   = 4'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pfx_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            pfx_q   <= pfx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid         <= 1'b0;
            reg0              <= '0;
            reg1              <= '0;
            imm               <= '0;
            use_imm           <= 1'b0;
            imm_as_input_b    <= 1'b0;
            use_other_reg_bus <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= !is_imx;
            if (!is_imx) begin
                reg0              <= d_reg0;
                reg1              <= d_reg1;
                imm               <= d_imm;
                use_imm           <= d_use_imm;
                imm_as_input_b    <= d_imm_b;
                use_other_reg_bus <= d_other;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_illegal <= 1'b0;
            err_sticky  <= 1'b0;
        end else if (!flush && accept) begin
            if (!is_imx)
                out_illegal <= is_illegal;
            if (is_illegal)
                err_sticky <= 1'b1;
        end
    end
`else
    assign out_illegal = 1'b0;
    assign err_sticky  = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table-driven stream with a scoreboard queue and random backpressure,
// followed by directed stall, flush and asynchronous reset sequences.
module tb_decode_stage;

    logic       clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [8:0] instr;
    logic [3:0] reg0, reg1;
    logic [7:0] imm;
    logic       use_imm, imm_as_input_b, use_other_reg_bus, out_illegal, err_sticky;
    logic [19:0] ov;

    int n_pass = 0;
    int n_total = 0;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    decode_stage #(.RW(4), .DW(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg0(reg0), .reg1(reg1), .imm(imm),
        .use_imm(use_imm), .imm_as_input_b(imm_as_input_b),
        .use_other_reg_bus(use_other_reg_bus),
        .out_illegal(out_illegal), .err_sticky(err_sticky)
    );

    assign ov = {reg0, reg1, imm, use_imm, imm_as_input_b, use_other_reg_bus, out_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  instr;
        bit          imx;
        logic [19:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [19:0] sb[$];

    function automatic logic [19:0] mk(input int r0, input int r1, input int im,
                                       input bit ui, input bit ib, input bit ob, input bit il);
        return {4'(r0), 4'(r1), 8'(im), ui, ib, ob, il};
    endfunction

    task automatic add(input logic [8:0] i, input bit imx, input logic [19:0] e);
        vec_t v;
        v.instr = i;
        v.imx   = imx;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout/unexpected, expected completion", name);
    endtask

    task automatic run_table();
        int idx = 0;
        int cyc = 0;
        logic [19:0] e;
        while ((idx < vecs.size() || sb.size() > 0) && cyc < 500) begin
            @(posedge clk); #1;
            in_valid  = (idx < vecs.size());
            if (idx < vecs.size()) instr = vecs[idx].instr;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) fail_now("table_extra_output");
                else begin
                    e = sb.pop_front();
                    chk("table_out", 32'(ov), 32'(e));
                end
            end
            if (in_valid && in_ready) begin
                if (!vecs[idx].imx) sb.push_back(vecs[idx].exp);
                idx++;
            end
            cyc++;
        end
        if (cyc >= 500) fail_now("table_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    localparam logic [8:0] I_A = 9'b000011101;
    localparam logic [8:0] I_B = 9'b010111001;
    localparam logic [8:0] I_C = 9'b110000101;
    localparam logic [8:0] I_D = 9'b100001010;

    initial begin
        logic [19:0] ea, eb, ec, ed;
        ea = mk(3, 5, 0, 0, 0, 0, 0);
        eb = mk(2, 1, 0, 0, 0, 0, 0);
        ec = mk(0, 0, 'h45, 1, 0, 0, 0);
        ed = mk(0, 0, 'h0A, 1, 0, 0, 0);

        add(I_A,          0, ea);
        add(9'b100001010, 0, mk(0, 0, 'h0A, 1, 0, 0, 0));
        add(9'b110010011, 1, '0);
        add(9'b100001010, 0, mk(0, 0, 'h3A, 1, 0, 0, 0));
        add(9'b100001010, 0, mk(0, 0, 'h0A, 1, 0, 0, 0));
        add(I_C,          0, ec);
        add(9'b101010110, 0, mk(0, 6, 0, 0, 1, 0, 0));
        add(I_B,          0, eb);
        add(9'b101110011, 0, mk(0, 3, 0, 0, 0, 1, 0));
        add(9'b101111101, 0, mk(5, 0, 0, 0, 0, 0, 0));
        add(9'b101100110, 0, mk(6, 0, 0, 0, 0, 0, 0));
        add(9'b101000111, 0, mk(7, 0, 0, 0, 0, 0, 0));
        add(9'b110100101, 0, mk(0, 0, 0, 0, 0, 0, TRAP));
        add(9'b110011111, 1, '0);
        add(9'b110010001, 1, '0);
        add(9'b100000101, 0, mk(0, 0, 'h15, 1, 0, 0, 0));
        add(9'b110010110, 1, '0);
        add(9'b000001010, 0, mk(1, 2, 0, 0, 0, 0, 0));
        add(9'b100000011, 0, mk(0, 0, 'h03, 1, 0, 0, 0));
        add(9'b111111111, 0, mk(0, 0, 0, 0, 0, 0, TRAP));
        add(9'b100111111, 0, mk(0, 0, 'h0F, 1, 0, 0, 0));

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        #2;
        chk("reset_fields", 32'(ov), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_sticky", 32'(err_sticky), 32'h0);
        #10 reset = 1'b0;

        run_table();

        // Stall: one held output, three instructions waiting, then drain 1/cycle.
        in_valid = 1'b1; instr = I_A; out_ready = 1'b0;
        @(posedge clk); #1;
        instr = I_B;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_hold", 32'(ov), 32'(ea));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); chk("drain_a", 32'(ov), 32'(ea));
        @(posedge clk); #1; instr = I_C;
        @(negedge clk); chk("drain_b", 32'(ov), 32'(eb));
        @(posedge clk); #1; instr = I_D;
        @(negedge clk); chk("drain_c", 32'(ov), 32'(ec));
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); chk("drain_d", 32'(ov), 32'(ed));
        chk("drain_d_valid", 32'(out_valid), 32'h1);
        @(posedge clk); #1;
        @(negedge clk); chk("drain_empty", 32'(out_valid), 32'h0);

        // Flush discards a pending prefix and the instruction presented with it.
        @(posedge clk); #1;
        in_valid = 1'b1; instr = 9'b110011111;
        @(posedge clk); #1;
        instr = 9'b100000001; flush = 1'b1;
        @(negedge clk); chk("imx_no_output", 32'(out_valid), 32'h0);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk); chk("flush_drop", 32'(out_valid), 32'h0);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("jg_after_flush_valid", 32'(out_valid), 32'h1);
        chk("jg_after_flush", 32'(ov), 32'(mk(0, 0, 'h01, 1, 0, 0, 0)));

        // Flush of a held output.
        @(posedge clk); #1;
        in_valid = 1'b1; instr = I_A; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk); chk("held_before_flush", 32'(out_valid), 32'h1);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk); chk("flush_held", 32'(out_valid), 32'h0);

        // Asynchronous reset while stalled.
        @(posedge clk); #1;
        in_valid = 1'b1; instr = I_D; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); chk("pre_reset_valid", 32'(out_valid), 32'h1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'h0);
        chk("async_reset_fields", 32'(ov), 32'h0);
        chk("async_reset_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk); reset = 1'b0;

        // Illegal opcode and sticky error across flush.
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; instr = 9'h1FF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("illegal_valid", 32'(out_valid), 32'h1);
        chk("illegal_fields", 32'(ov), 32'(mk(0, 0, 0, 0, 0, 0, TRAP)));
        chk("illegal_sticky", 32'(err_sticky), 32'(TRAP));
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", 32'(out_valid), 32'h0);
        chk("sticky_survives_flush", 32'(err_sticky), 32'(TRAP));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
